// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter_if : fetch/data request, memory and IO register bundle
// Rev 1.0
// ============================================================================
interface mem_port_arbiter_if;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_rdata;
  logic        if_done;
  logic        if_err;

  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        d_done;
  logic        d_err;

  logic        mem_re;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  logic [15:0] io_in_data;
  logic        io_in_valid;
  logic        io_in_ack;
  logic [15:0] io_out_data;
  logic        io_out_valid;
  logic        io_out_ready;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
           io_in_data, io_in_valid, io_out_ready,
    output if_rdata, if_done, if_err, d_rdata, d_done, d_err,
           mem_re, mem_we, mem_addr, mem_wdata, io_in_ack, io_out_data, io_out_valid
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
           io_in_data, io_in_valid, io_out_ready,
    input  if_rdata, if_done, if_err, d_rdata, d_done, d_err,
           mem_re, mem_we, mem_addr, mem_wdata, io_in_ack, io_out_data, io_out_valid
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter : shares one single-ported memory and the IO registers
//                    between fetch and data ports (data has priority).
// Optional IO wait timeout: MEM_PORT_ARBITER_TIMEOUT_EN
// Rev 1.0
// ============================================================================
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT     = 2,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input wire                clk,
  input wire                rst_n,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ACCESS   = 3'd1,
    S_IN_WAIT  = 3'd2,
    S_OUT_WAIT = 3'd3,
    S_ERR      = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  typedef enum logic [1:0] {K_ERR, K_MEM, K_IN, K_OUT} kind_t;

  localparam logic [2:0] C_LAT_LAST = 3'(MEM_LAT - 1);

  if (MEM_LAT < 1 || MEM_LAT > 7 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_param_check
    $error("mem_port_arbiter: MEM_LAT or TIMEOUT_CYC out of range");
  end

  function automatic kind_t decode(input logic is_d, input logic we, input logic [15:0] a);
    kind_t k;
    k = K_ERR;
    if (a[0])                k = K_ERR;
    else if (a < 16'd256)    k = (is_d && we) ? K_ERR : K_MEM;
    else if (a < 16'd1024)   k = is_d ? K_MEM : K_ERR;
    else if (a == 16'd1024)  k = (is_d && !we) ? K_IN : K_ERR;
    else if (a == 16'd1026)  k = (is_d && we) ? K_OUT : K_ERR;
    return k;
  endfunction

  state_t      state_q;
  logic        is_data_q;
  logic        we_q;
  logic [2:0]  lat_q;
  logic [15:0] mem_addr_q;
  logic [15:0] mem_wdata_q;
  logic [15:0] if_rdata_q;
  logic [15:0] d_rdata_q;
  logic [15:0] io_out_data_q;
  logic        if_done_q;
  logic        if_err_q;
  logic        d_done_q;
  logic        d_err_q;
  logic        mem_re_q;
  logic        mem_we_q;
  logic        io_out_valid_q;

  logic        sel_req;
  logic        sel_data;
  logic        sel_we;
  logic [15:0] sel_addr;
  kind_t       sel_kind;
  logic        to_hit;

  assign sel_req  = bus.d_req | bus.if_req;
  assign sel_data = bus.d_req;
  assign sel_we   = bus.d_req & bus.d_we;
  assign sel_addr = bus.d_req ? bus.d_addr : bus.if_addr;
  assign sel_kind = decode(sel_data, sel_we, sel_addr);

`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
  localparam logic [7:0] C_TO_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] to_q;
  logic       io_stall;

  assign io_stall = ((state_q == S_IN_WAIT)  && !bus.io_in_valid) ||
                    ((state_q == S_OUT_WAIT) && !bus.io_out_ready);
  assign to_hit   = io_stall && (to_q == C_TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  to_q <= '0;
    else if (io_stall && !to_hit) to_q <= to_q + 8'd1;
    else                         to_q <= '0;
  end
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      is_data_q      <= 1'b0;
      we_q           <= 1'b0;
      lat_q          <= '0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      if_rdata_q     <= '0;
      d_rdata_q      <= '0;
      io_out_data_q  <= '0;
      if_done_q      <= 1'b0;
      if_err_q       <= 1'b0;
      d_done_q       <= 1'b0;
      d_err_q        <= 1'b0;
      mem_re_q       <= 1'b0;
      mem_we_q       <= 1'b0;
      io_out_valid_q <= 1'b0;
    end else begin
      // done/err are single-cycle pulses: high only in the ERR/DONE state
      if_done_q <= 1'b0;
      if_err_q  <= 1'b0;
      d_done_q  <= 1'b0;
      d_err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (sel_req) begin
            is_data_q  <= sel_data;
            we_q       <= sel_we;
            mem_addr_q <= sel_addr;
            lat_q      <= C_LAT_LAST;
            if (sel_data) mem_wdata_q <= bus.d_wdata;
            case (sel_kind)
              K_MEM: begin
                state_q  <= S_ACCESS;
                mem_re_q <= !sel_we;
                mem_we_q <= sel_we;
              end
              K_IN:  state_q <= S_IN_WAIT;
              K_OUT: begin
                state_q        <= S_OUT_WAIT;
                io_out_valid_q <= 1'b1;
                io_out_data_q  <= bus.d_wdata;
              end
              default: begin
                state_q   <= S_ERR;
                if_done_q <= !sel_data;
                if_err_q  <= !sel_data;
                d_done_q  <= sel_data;
                d_err_q   <= sel_data;
              end
            endcase
          end
        end
        S_ACCESS: begin
          if (lat_q == 3'd0) begin
            mem_re_q <= 1'b0;
            mem_we_q <= 1'b0;
            if (!we_q) begin
              if (is_data_q) d_rdata_q  <= bus.mem_rdata;
              else           if_rdata_q <= bus.mem_rdata;
            end
            if_done_q <= !is_data_q;
            d_done_q  <= is_data_q;
            state_q   <= S_DONE;
          end else begin
            lat_q <= lat_q - 3'd1;
          end
        end
        S_IN_WAIT: begin
          if (bus.io_in_valid) begin
            d_rdata_q <= bus.io_in_data;
            d_done_q  <= 1'b1;
            state_q   <= S_DONE;
          end else if (to_hit) begin
            d_done_q <= 1'b1;
            d_err_q  <= 1'b1;
            state_q  <= S_ERR;
          end
        end
        S_OUT_WAIT: begin
          if (bus.io_out_ready) begin
            io_out_valid_q <= 1'b0;
            d_done_q       <= 1'b1;
            state_q        <= S_DONE;
          end else if (to_hit) begin
            io_out_valid_q <= 1'b0;
            d_done_q       <= 1'b1;
            d_err_q        <= 1'b1;
            state_q        <= S_ERR;
          end
        end
        S_ERR:   state_q <= S_IDLE;
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // The consume pulse must coincide with the cycle the input data is taken
  assign bus.io_in_ack    = (state_q == S_IN_WAIT) && bus.io_in_valid;

  assign bus.if_rdata     = if_rdata_q;
  assign bus.if_done      = if_done_q;
  assign bus.if_err       = if_err_q;
  assign bus.d_rdata      = d_rdata_q;
  assign bus.d_done       = d_done_q;
  assign bus.d_err        = d_err_q;
  assign bus.mem_re       = mem_re_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.io_out_data  = io_out_data_q;
  assign bus.io_out_valid = io_out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// tb_mem_port_arbiter: directed and randomized requests checked against a
// transaction-level model of the address map, arbitration and latencies.
module tb_mem_port_arbiter;
  localparam int MEM_LAT     = 2;
  localparam int TIMEOUT_CYC = 8;
  localparam int K_ERR = 0, K_MEM = 1, K_IN = 2, K_OUT = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic mem_init = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.MEM_LAT(MEM_LAT), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  logic [15:0] mem_arr [0:1023];
  logic [15:0] ref_mem [0:1023];

  function automatic logic [15:0] init_val(input int i);
    return (i == 10) ? 16'hA5A5 : 16'(i * 40503 + 4660);
  endfunction

  assign bus.mem_rdata = mem_arr[bus.mem_addr[9:0]];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem_arr[i] <= init_val(i);
    end else if (bus.mem_we) begin
      mem_arr[bus.mem_addr[9:0]] <= bus.mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int kind_of(input bit is_d, input bit we, input int a);
    if (a % 2 != 0) return K_ERR;
    if (a < 256)    return (is_d && we) ? K_ERR : K_MEM;
    if (a < 1024)   return is_d ? K_MEM : K_ERR;
    if (a == 1024)  return (is_d && !we) ? K_IN : K_ERR;
    if (a == 1026)  return (is_d && we) ? K_OUT : K_ERR;
    return K_ERR;
  endfunction

  function automatic int lat_of(input int k, input int io_n);
    if (k == K_ERR) return 1;
    if (k == K_MEM) return MEM_LAT + 1;
    return io_n + 1;
  endfunction

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 7))
      0, 1:    return 16'(2 * $urandom_range(0, 127));
      2, 3:    return 16'(256 + 2 * $urandom_range(0, 383));
      4:       return 16'd1024;
      5:       return 16'd1026;
      6:       return 16'(2 * $urandom_range(0, 511) + 1);
      default: return 16'($urandom_range(1028, 65535));
    endcase
  endfunction

  function automatic logic [87:0] outs();
    return {bus.if_rdata, bus.d_rdata, bus.mem_addr, bus.mem_wdata, bus.io_out_data,
            bus.if_done, bus.if_err, bus.d_done, bus.d_err, bus.mem_re, bus.mem_we,
            bus.io_in_ack, bus.io_out_valid};
  endfunction

  // One scenario: optional data request and optional fetch raised together.
  task automatic run(input bit f_en, input logic [15:0] f_a, input bit d_en, input bit d_w,
                     input logic [15:0] d_a, input logic [15:0] d_wd, input int io_n,
                     input logic [15:0] in_data);
    int dk, fk, d_end, f_beg, f_end, last;
    int d_seen, f_seen, d_cnt, f_cnt, strobe_bad, ack_bad, outv_bad;
    logic d_err_s, f_err_s;
    logic [15:0] d_rd_s, f_rd_s, d_exp, f_exp;
    dk    = d_en ? kind_of(1'b1, d_w, int'(d_a)) : K_ERR;
    fk    = f_en ? kind_of(1'b0, 1'b0, int'(f_a)) : K_ERR;
    d_end = d_en ? lat_of(dk, io_n) : 0;
    f_beg = d_en ? d_end + 1 : 0;
    f_end = f_en ? f_beg + lat_of(fk, io_n) : 0;
    last  = ((d_end > f_end) ? d_end : f_end) + 2;
    d_exp = (dk == K_IN) ? in_data : ref_mem[d_a[9:0]];
    f_exp = ref_mem[f_a[9:0]];
    d_seen = 0; f_seen = 0; d_cnt = 0; f_cnt = 0;
    strobe_bad = 0; ack_bad = 0; outv_bad = 0;
    d_err_s = 1'b0; f_err_s = 1'b0; d_rd_s = '0; f_rd_s = '0;

    @(negedge clk);
    bus.d_req = d_en; bus.d_we = d_w; bus.d_addr = d_a; bus.d_wdata = d_wd;
    bus.if_req = f_en; bus.if_addr = f_a; bus.io_in_data = in_data;
    for (int c = 1; c <= last; c++) begin
      logic exp_re, exp_we, exp_ov, exp_ack;
      logic [15:0] exp_addr;
      @(posedge clk); #1;
      exp_re = 1'b0; exp_we = 1'b0; exp_addr = '0;
      if (d_en && dk == K_MEM && c <= MEM_LAT) begin
        exp_re = !d_w; exp_we = d_w; exp_addr = d_a;
      end
      if (f_en && fk == K_MEM && c > f_beg && c <= f_beg + MEM_LAT) begin
        exp_re = 1'b1; exp_addr = f_a;
      end
      if (bus.mem_re !== exp_re || bus.mem_we !== exp_we) strobe_bad++;
      else if ((exp_re || exp_we) && bus.mem_addr !== exp_addr) strobe_bad++;
      else if (exp_we && bus.mem_wdata !== d_wd) strobe_bad++;
      exp_ov = d_en && dk == K_OUT && c <= io_n;
      if (bus.io_out_valid !== exp_ov || (exp_ov && bus.io_out_data !== d_wd)) outv_bad++;
      if (bus.d_done === 1'b1) begin
        d_cnt++;
        if (d_seen == 0) begin d_seen = c; d_err_s = bus.d_err; d_rd_s = bus.d_rdata; end
      end
      if (bus.if_done === 1'b1) begin
        f_cnt++;
        if (f_seen == 0) begin f_seen = c; f_err_s = bus.if_err; f_rd_s = bus.if_rdata; end
      end
      @(negedge clk);
      if (c == d_seen) bus.d_req = 1'b0;
      else if (d_seen == 0) begin
        bus.d_addr = 16'($urandom); bus.d_wdata = 16'($urandom); bus.d_we = 1'($urandom);
      end
      if (c == f_seen) bus.if_req = 1'b0;
      else if (f_seen == 0 && c > f_beg) bus.if_addr = 16'($urandom);
      bus.io_in_valid  = d_en && dk == K_IN  && c == io_n;
      bus.io_out_ready = d_en && dk == K_OUT && c == io_n;
      #1;
      exp_ack = d_en && dk == K_IN && c == io_n;
      if (bus.io_in_ack !== exp_ack) ack_bad++;
    end
    bus.d_req = 1'b0; bus.if_req = 1'b0; bus.io_in_valid = 1'b0; bus.io_out_ready = 1'b0;

    check("d_done_count", 32'(d_cnt), d_en ? 32'd1 : 32'd0);
    check("if_done_count", 32'(f_cnt), f_en ? 32'd1 : 32'd0);
    if (d_en) begin
      check("d_done_cycle", 32'(d_seen), 32'(d_end));
      check("d_err", 32'(d_err_s), 32'(dk == K_ERR));
      if (!d_w && (dk == K_MEM || dk == K_IN)) check("d_rdata", 32'(d_rd_s), 32'(d_exp));
    end
    if (f_en) begin
      check("if_done_cycle", 32'(f_seen), 32'(f_end));
      check("if_err", 32'(f_err_s), 32'(fk == K_ERR));
      if (fk == K_MEM) check("if_rdata", 32'(f_rd_s), 32'(f_exp));
    end
    check("mem_strobes", 32'(strobe_bad), 32'd0);
    check("io_out_valid", 32'(outv_bad), 32'd0);
    check("io_in_ack", 32'(ack_bad), 32'd0);
    if (d_en && d_w && dk == K_MEM) ref_mem[d_a[9:0]] = d_wd;
  endtask

  task automatic reset_abort(input bit w, input logic [15:0] a, input int wait_c, input string tag);
    int dn;
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = w; bus.d_addr = a; bus.d_wdata = 16'hBEEF;
    repeat (wait_c) @(negedge clk);
    check({tag, "_busy_before_reset"}, 32'(w ? bus.io_out_valid : bus.mem_re), 32'd1);
    rst_n = 1'b0; bus.d_req = 1'b0;
    #1;
    check({tag, "_outputs_cleared"}, 32'(outs() !== 88'd0), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.d_done !== 1'b0 || bus.if_done !== 1'b0) dn++;
    end
    check({tag, "_no_done_after_reset"}, 32'(dn), 32'd0);
  endtask

`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
  task automatic timeout_case(input bit w, input logic [15:0] a, input string tag);
    int seen, acks;
    logic errv, ovb;
    seen = 0; acks = 0; errv = 1'b0; ovb = 1'b0;
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = w; bus.d_addr = a; bus.d_wdata = 16'h5555;
    for (int c = 1; c <= TIMEOUT_CYC + 4; c++) begin
      @(posedge clk); #1;
      if (bus.d_done === 1'b1 && seen == 0) begin seen = c; errv = bus.d_err; ovb = bus.io_out_valid; end
      @(negedge clk);
      if (c == seen) bus.d_req = 1'b0;
      #1;
      if (bus.io_in_ack === 1'b1) acks++;
    end
    bus.d_req = 1'b0;
    check({tag, "_done_cycle"}, 32'(seen), 32'(TIMEOUT_CYC + 1));
    check({tag, "_err"}, 32'(errv), 32'd1);
    check({tag, "_out_valid_dropped"}, 32'(ovb), 32'd0);
    check({tag, "_no_ack"}, 32'(acks), 32'd0);
  endtask
`endif

  initial begin
    bus.if_req = 1'b0; bus.if_addr = '0; bus.d_req = 1'b0; bus.d_we = 1'b0;
    bus.d_addr = '0; bus.d_wdata = '0; bus.io_in_data = '0;
    bus.io_in_valid = 1'b0; bus.io_out_ready = 1'b0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs_zero", 32'(outs() !== 88'd0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; mem_init = 1'b0;

    // fetch, bad fetch, bad store, contention, stack store/load
    run(1'b1, 16'd10,  1'b0, 1'b0, 16'd0,    16'd0,    1, 16'd0);
    run(1'b1, 16'd11,  1'b0, 1'b0, 16'd0,    16'd0,    1, 16'd0);
    run(1'b0, 16'd0,   1'b1, 1'b1, 16'd10,   16'h7777, 1, 16'd0);
    run(1'b1, 16'd10,  1'b1, 1'b0, 16'd258,  16'd0,    1, 16'd0);
    run(1'b0, 16'd0,   1'b1, 1'b1, 16'd258,  16'h1234, 1, 16'd0);
    run(1'b0, 16'd0,   1'b1, 1'b0, 16'd258,  16'd0,    1, 16'd0);
    // IO and remaining error classes
    run(1'b0, 16'd0,   1'b1, 1'b0, 16'd1024, 16'd0,    5, 16'h0042);
    run(1'b0, 16'd0,   1'b1, 1'b1, 16'd1026, 16'hC0DE, 4, 16'd0);
    run(1'b0, 16'd0,   1'b1, 1'b0, 16'd2048, 16'd0,    1, 16'd0);
    run(1'b0, 16'd0,   1'b1, 1'b1, 16'd1024, 16'h1111, 1, 16'd0);
    run(1'b0, 16'd0,   1'b1, 1'b0, 16'd1026, 16'd0,    1, 16'd0);
    run(1'b1, 16'd300, 1'b0, 1'b0, 16'd0,    16'd0,    1, 16'd0);
    run(1'b1, 16'd256, 1'b1, 1'b1, 16'd1026, 16'hABCD, 3, 16'd0);

    for (int i = 0; i < 60; i++) begin
      bit fe, de, w;
      fe = 1'($urandom_range(0, 1));
      de = 1'($urandom_range(0, 1));
      if (!fe && !de) de = 1'b1;
      w  = 1'($urandom_range(0, 1));
      run(fe, rand_addr(), de, w, rand_addr(), 16'($urandom), $urandom_range(1, 6), 16'($urandom));
    end

    reset_abort(1'b0, 16'd300,  1, "rst_in_access");
    reset_abort(1'b1, 16'd1026, 2, "rst_in_out_wait");
    run(1'b1, 16'd20, 1'b1, 1'b0, 16'd600, 16'd0, 1, 16'd0);

`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
    timeout_case(1'b0, 16'd1024, "timeout_in");
    timeout_case(1'b1, 16'd1026, "timeout_out");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequential front end for the memory/IO address map; shares one single-ported memory between the instruction-fetch port and the data (load/store) port.
- Decodes each accepted request against the fixed map, drives the memory strobes for a fixed latency, and runs handshakes for the input and output IO registers.
- Returns done/err pulses to the control unit.
- Sits between the control unit and the instruction/stack memory block.

Parameters:
- MEM_LAT, 2: cycles mem_re/mem_we held per access (1..7).
- TIMEOUT_CYC, 255: IO wait limit in cycles; used only with the optional feature.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- if_req  input  1  fetch request; held until if_done
- if_addr  input  16  fetch address
- if_rdata  output  16  fetched word; valid while if_done=1, then held
- if_done  output  1  one-cycle completion pulse
- if_err  output  1  one-cycle error pulse, coincident with if_done
- d_req  input  1  data request; held until d_done
- d_we  input  1  1=store, 0=load
- d_addr  input  16  data address
- d_wdata  input  16  store data
- d_rdata  output  16  load result; valid while d_done=1, then held
- d_done  output  1  one-cycle completion pulse
- d_err  output  1  one-cycle error pulse, coincident with d_done
- mem_re  output  1  memory read strobe
- mem_we  output  1  memory write strobe
- mem_addr  output  16  latched address
- mem_wdata  output  16  latched store data
- mem_rdata  input  16  memory read data
- io_in_data  input  16  input register data
- io_in_valid  input  1  input data available
- io_in_ack  output  1  one-cycle consume pulse
- io_out_data  output  16  output register data
- io_out_valid  output  1  output data offered
- io_out_ready  input  1  output sink accepts

Behaviour:
- Reset:
  - All outputs 0; rdata/mem_addr/mem_wdata/io_out_data registers cleared; state IDLE.
  - Reset asserted mid-access or mid-IO-wait aborts immediately; no done is issued for the aborted request.
- Address map (16-bit, all accesses word-aligned):
  - 0..255: instruction memory; fetch read OK, data load OK, data store is an error.
  - 256..1023: stack/data memory; data read/write OK, fetch is an error.
  - 1024: input register, data load only.
  - 1026: output register, data store only.
  - All other addresses are errors: any odd address, 1028 and above, store to 1024, load from 1026.
- States: IDLE, ACCESS, IN_WAIT, OUT_WAIT, ERR, DONE.
- IDLE:
  - Samples requests each cycle. d_req has fixed priority over if_req when both are high.
  - The winner's address/data/we are latched at that edge.
  - Next state by decode: error -> ERR; memory -> ACCESS; 1024 -> IN_WAIT; 1026 -> OUT_WAIT.
  - The loser keeps waiting; its req is held by contract.
- ACCESS:
  - mem_re (read) or mem_we (write) is high for exactly MEM_LAT cycles with mem_addr stable.
  - On the final cycle's edge, mem_rdata is captured into the winner's rdata; then -> DONE.
- IN_WAIT:
  - On the first cycle with io_in_valid=1: io_in_data is captured into d_rdata and io_in_ack is pulsed that same cycle.
  - Then -> DONE.
- OUT_WAIT:
  - io_out_valid=1 with io_out_data = latched wdata.
  - On the first cycle with io_out_ready=1, io_out_valid drops next cycle; then -> DONE.
- ERR: the winner's done+err pulse for one cycle; no mem strobe or IO signal toggles. Then -> IDLE.
- DONE: the winner's done pulses for one cycle. Then -> IDLE.
- Latency:
  - Memory access: done is asserted MEM_LAT+1 cycles after the request-sampling edge.
  - Error: done is asserted 1 cycle after that edge.
- Requester contract:
  - req is held until done. req still high in the cycle after done is sampled as a new request.
  - Changing addr/data while waiting has no effect; values are latched at acceptance.
- Back-to-back: the minimum gap between two accesses is one IDLE cycle.
- Starvation: a continuously high d_req starves fetch by design; the control unit never does this.

Optional Feature:
- Macro: MEM_PORT_ARBITER_TIMEOUT_EN.
- Defined:
  - An 8-bit counter runs in IN_WAIT/OUT_WAIT.
  - After TIMEOUT_CYC cycles with no valid/ready, the block goes to ERR: d_done+d_err pulse, io_out_valid drops, no io_in_ack.
  - The counter clears on leaving the state.
- Undefined: IO waits are unbounded; no counter is present.

Test Plan:
- Fetch: if_req=1, if_addr=10, mem_rdata=16'hA5A5, MEM_LAT=2 -> mem_re high 2 cycles; if_done and if_rdata=16'hA5A5 on cycle 3; if_err=0.
- Bad fetch and store:
  - if_addr=11 -> if_done+if_err on the next cycle; mem_re never rises.
  - d_we=1, d_addr=10 -> d_err.
- Contention: d_req (load 258) and if_req (10) raised the same cycle -> data access first (mem_addr=258); fetch starts after d_done plus one IDLE cycle.
- Stack store: d_we=1, d_addr=258, d_wdata=16'h1234 -> mem_we high 2 cycles, mem_wdata=16'h1234, d_done with d_err=0.
- IO:
  - Load 1024 with io_in_valid raised after 5 cycles, io_in_data=16'h0042 -> io_in_ack pulse, d_rdata=16'h0042.
  - Store 1026 -> io_out_valid held until io_out_ready.
  - Address 2048 -> d_err.
- Reset and timeout:
  - rst_n low during ACCESS -> all outputs 0 immediately; no done afterwards.
  - With the macro defined and TIMEOUT_CYC=8, load 1024 with io_in_valid=0 -> d_err after 8 cycles.
